// File: rtl/i_decode.sv
// MIPS ID stage: 32x32 register file, main control decode, sign extension, ID/EX latch.
// Define REGFILE_BYPASS_EN for write-before-read forwarding of same-cycle write-back.
module i_decode #(
    parameter int NREGS   = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] IF_ID_instr,
    input  logic [INSTR_W-1:0] IF_ID_npc,
    input  logic               EX_MEM_PCsrc,
    input  logic               MEM_WB_RegWrite,
    input  logic [4:0]         MEM_WB_WriteReg,
    input  logic [INSTR_W-1:0] MEM_WB_WriteData,
    output logic [1:0]         ID_EX_wb,
    output logic [2:0]         ID_EX_m,
    output logic [3:0]         ID_EX_ex,
    output logic [INSTR_W-1:0] ID_EX_npc,
    output logic [INSTR_W-1:0] ID_EX_rd1,
    output logic [INSTR_W-1:0] ID_EX_rd2,
    output logic [INSTR_W-1:0] ID_EX_sign_ext,
    output logic [4:0]         ID_EX_rt,
    output logic [4:0]         ID_EX_rd
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    logic [INSTR_W-1:0] rf_q [NREGS];

    logic [5:0]         opcode;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic               wb_en;

    logic [8:0]         ctrl_d;
    logic [INSTR_W-1:0] rd1_d;
    logic [INSTR_W-1:0] rd2_d;
    logic [INSTR_W-1:0] sext_d;

    logic [1:0]         wb_q;
    logic [2:0]         m_q;
    logic [3:0]         ex_q;
    logic [INSTR_W-1:0] npc_q;
    logic [INSTR_W-1:0] rd1_q;
    logic [INSTR_W-1:0] rd2_q;
    logic [INSTR_W-1:0] sext_q;
    logic [4:0]         rt_q;
    logic [4:0]         rd_q;

    assign opcode = IF_ID_instr[31:26];
    assign rs     = IF_ID_instr[25:21];
    assign rt     = IF_ID_instr[20:16];
    assign rd     = IF_ID_instr[15:11];
    assign sext_d = {{(INSTR_W-16){IF_ID_instr[15]}}, IF_ID_instr[15:0]};
    assign wb_en  = MEM_WB_RegWrite && (MEM_WB_WriteReg != 5'd0);

    // r0 is never written, so its storage stays zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en) begin
            rf_q[MEM_WB_WriteReg] <= MEM_WB_WriteData;
        end
    end

    always_comb begin
        rd1_d = (rs == 5'd0) ? '0 : rf_q[rs];
        rd2_d = (rt == 5'd0) ? '0 : rf_q[rt];
`ifdef REGFILE_BYPASS_EN
        if (wb_en && (MEM_WB_WriteReg == rs)) begin
            rd1_d = MEM_WB_WriteData;
        end
        if (wb_en && (MEM_WB_WriteReg == rt)) begin
            rd2_d = MEM_WB_WriteData;
        end
`endif
    end

    // {RegWrite,MemtoReg, Branch,MemRead,MemWrite, RegDst,ALUOp[1:0],ALUSrc}
    always_comb begin
        ctrl_d = 9'b0_0_000_0000;
        unique case (1'b1)
            (opcode == OP_RTYPE): ctrl_d = 9'b10_000_1100;
            (opcode == OP_LW):    ctrl_d = 9'b11_010_0001;
            (opcode == OP_SW):    ctrl_d = 9'b00_001_0001;
            (opcode == OP_BEQ):   ctrl_d = 9'b00_100_0010;
            default:              ctrl_d = 9'b0_0_000_0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_q   <= '0;
            m_q    <= '0;
            ex_q   <= '0;
            npc_q  <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            sext_q <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
        end else begin
            if (EX_MEM_PCsrc) begin
                wb_q <= '0;
                m_q  <= '0;
                ex_q <= '0;
            end else begin
                wb_q <= ctrl_d[8:7];
                m_q  <= ctrl_d[6:4];
                ex_q <= ctrl_d[3:0];
            end
            npc_q  <= IF_ID_npc;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            sext_q <= sext_d;
            rt_q   <= rt;
            rd_q   <= rd;
        end
    end

    assign ID_EX_wb       = wb_q;
    assign ID_EX_m        = m_q;
    assign ID_EX_ex       = ex_q;
    assign ID_EX_npc      = npc_q;
    assign ID_EX_rd1      = rd1_q;
    assign ID_EX_rd2      = rd2_q;
    assign ID_EX_sign_ext = sext_q;
    assign ID_EX_rt       = rt_q;
    assign ID_EX_rd       = rd_q;

endmodule

// File: tb/tb_i_decode.sv
// Bench for i_decode: directed vector table followed by randomized traffic
// checked against an array-based architectural model.
module tb_i_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_npc;
    logic        EX_MEM_PCsrc;
    logic        MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_WriteReg;
    logic [31:0] MEM_WB_WriteData;
    logic [1:0]  ID_EX_wb;
    logic [2:0]  ID_EX_m;
    logic [3:0]  ID_EX_ex;
    logic [31:0] ID_EX_npc;
    logic [31:0] ID_EX_rd1;
    logic [31:0] ID_EX_rd2;
    logic [31:0] ID_EX_sign_ext;
    logic [4:0]  ID_EX_rt;
    logic [4:0]  ID_EX_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i_decode dut (
        .clk              (clk),
        .reset            (reset),
        .IF_ID_instr      (IF_ID_instr),
        .IF_ID_npc        (IF_ID_npc),
        .EX_MEM_PCsrc     (EX_MEM_PCsrc),
        .MEM_WB_RegWrite  (MEM_WB_RegWrite),
        .MEM_WB_WriteReg  (MEM_WB_WriteReg),
        .MEM_WB_WriteData (MEM_WB_WriteData),
        .ID_EX_wb         (ID_EX_wb),
        .ID_EX_m          (ID_EX_m),
        .ID_EX_ex         (ID_EX_ex),
        .ID_EX_npc        (ID_EX_npc),
        .ID_EX_rd1        (ID_EX_rd1),
        .ID_EX_rd2        (ID_EX_rd2),
        .ID_EX_sign_ext   (ID_EX_sign_ext),
        .ID_EX_rt         (ID_EX_rt),
        .ID_EX_rd         (ID_EX_rd)
    );

    typedef struct {
        logic        rst;
        logic        pcsrc;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [31:0] instr;
        logic [31:0] npc;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] e_npc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sext;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs[$];

    // Architectural register state for the random phase
    logic [31:0] mregs [32];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp, input int idx);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h",
                     name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset            = v.rst;
        EX_MEM_PCsrc     = v.pcsrc;
        MEM_WB_RegWrite  = v.we;
        MEM_WB_WriteReg  = v.wreg;
        MEM_WB_WriteData = v.wdata;
        IF_ID_instr      = v.instr;
        IF_ID_npc        = v.npc;
    endtask

    task automatic compare(input vec_t v, input int idx);
        chk("wb",   {30'd0, ID_EX_wb},  {30'd0, v.wb},  idx);
        chk("m",    {29'd0, ID_EX_m},   {29'd0, v.m},   idx);
        chk("ex",   {28'd0, ID_EX_ex},  {28'd0, v.ex},  idx);
        chk("npc",  ID_EX_npc,          v.e_npc,        idx);
        chk("rd1",  ID_EX_rd1,          v.rd1,          idx);
        chk("rd2",  ID_EX_rd2,          v.rd2,          idx);
        chk("sext", ID_EX_sign_ext,     v.sext,         idx);
        chk("rt",   {27'd0, ID_EX_rt},  {27'd0, v.rt},  idx);
        chk("rd",   {27'd0, ID_EX_rd},  {27'd0, v.rd},  idx);
    endtask

    function automatic vec_t mk(
        input logic rst, input logic pcsrc, input logic we,
        input logic [4:0] wreg, input logic [31:0] wdata,
        input logic [31:0] instr, input logic [31:0] npc,
        input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
        input logic [31:0] e_npc, input logic [31:0] rd1,
        input logic [31:0] rd2, input logic [31:0] sext,
        input logic [4:0] rt, input logic [4:0] rd);
        vec_t v;
        v.rst = rst; v.pcsrc = pcsrc; v.we = we; v.wreg = wreg;
        v.wdata = wdata; v.instr = instr; v.npc = npc;
        v.wb = wb; v.m = m; v.ex = ex; v.e_npc = e_npc;
        v.rd1 = rd1; v.rd2 = rd2; v.sext = sext; v.rt = rt; v.rd = rd;
        return v;
    endfunction

    // Control table straight from the opcode list: {wb, m, ex}
    function automatic logic [8:0] ctrl_of(input logic [5:0] op);
        if (op == 6'h00) return {2'b10, 3'b000, 4'b1100};
        if (op == 6'h23) return {2'b11, 3'b010, 4'b0001};
        if (op == 6'h2B) return {2'b00, 3'b001, 4'b0001};
        if (op == 6'h04) return {2'b00, 3'b100, 4'b0010};
        return 9'd0;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input vec_t v);
        if (a == 0) return 32'd0;
        if (BYP && v.we && v.wreg == a) return v.wdata;
        return mregs[a];
    endfunction

    initial begin
        logic [31:0] r9_after_flush;
        logic [31:0] r3_same;
        logic [8:0]  c;
        vec_t v;

        r9_after_flush = BYP ? 32'h0000_00AA : 32'd0;
        r3_same        = BYP ? 32'hA5A5_A5A5 : 32'd0;

        // rst pc we wreg wdata instr npc | wb m ex npc rd1 rd2 sext rt rd
        vecs.push_back(mk(1,0,1,5'd5,32'h1111_1111,32'h0000_0000,32'h4,
            2'b00,3'b000,4'b0000,32'h0,32'h0,32'h0,32'h0,5'd0,5'd0));
        vecs.push_back(mk(0,0,1,5'd5,32'hDEAD_BEEF,32'h0000_0000,32'h4,
            2'b10,3'b000,4'b1100,32'h4,32'h0,32'h0,32'h0,5'd0,5'd0));
        vecs.push_back(mk(1,0,0,5'd0,32'h0,32'h00A0_0000,32'h8,
            2'b00,3'b000,4'b0000,32'h0,32'h0,32'h0,32'h0,5'd0,5'd0));
        vecs.push_back(mk(0,0,0,5'd0,32'h0,32'h00A0_0000,32'h8,
            2'b10,3'b000,4'b1100,32'h8,32'h0,32'h0,32'h0,5'd0,5'd0));
        vecs.push_back(mk(0,0,1,5'd8,32'h1234_5678,32'h0000_0000,32'hC,
            2'b10,3'b000,4'b1100,32'hC,32'h0,32'h0,32'h0,5'd0,5'd0));
        vecs.push_back(mk(0,0,0,5'd0,32'h0,32'h0109_5020,32'h10,
            2'b10,3'b000,4'b1100,32'h10,32'h1234_5678,32'h0,
            32'h0000_5020,5'd9,5'd10));
        vecs.push_back(mk(0,0,0,5'd0,32'h0,32'h8D09_FFFC,32'h40,
            2'b11,3'b010,4'b0001,32'h40,32'h1234_5678,32'h0,
            32'hFFFF_FFFC,5'd9,5'd31));
        vecs.push_back(mk(0,0,0,5'd0,32'h0,32'hAD09_0004,32'h44,
            2'b00,3'b001,4'b0001,32'h44,32'h1234_5678,32'h0,
            32'h0000_0004,5'd9,5'd0));
        vecs.push_back(mk(0,1,0,5'd0,32'h0,32'h1109_0003,32'h50,
            2'b00,3'b000,4'b0000,32'h50,32'h1234_5678,32'h0,
            32'h0000_0003,5'd9,5'd0));
        vecs.push_back(mk(0,0,0,5'd0,32'h0,32'h1109_0003,32'h54,
            2'b00,3'b100,4'b0010,32'h54,32'h1234_5678,32'h0,
            32'h0000_0003,5'd9,5'd0));
        vecs.push_back(mk(0,1,1,5'd9,32'h0000_00AA,32'h0109_5020,32'h58,
            2'b00,3'b000,4'b0000,32'h58,32'h1234_5678,r9_after_flush,
            32'h0000_5020,5'd9,5'd10));
        vecs.push_back(mk(0,0,0,5'd0,32'h0,32'h0109_5020,32'h5C,
            2'b10,3'b000,4'b1100,32'h5C,32'h1234_5678,32'h0000_00AA,
            32'h0000_5020,5'd9,5'd10));
        vecs.push_back(mk(0,0,1,5'd0,32'hFFFF_FFFF,32'h0000_0000,32'h60,
            2'b10,3'b000,4'b1100,32'h60,32'h0,32'h0,32'h0,5'd0,5'd0));
        vecs.push_back(mk(0,0,0,5'd0,32'h0,32'h0000_0000,32'h64,
            2'b10,3'b000,4'b1100,32'h64,32'h0,32'h0,32'h0,5'd0,5'd0));
        vecs.push_back(mk(0,0,1,5'd3,32'hA5A5_A5A5,32'h0060_0000,32'h68,
            2'b10,3'b000,4'b1100,32'h68,r3_same,32'h0,32'h0,5'd0,5'd0));
        vecs.push_back(mk(0,0,0,5'd0,32'h0,32'h0060_0000,32'h6C,
            2'b10,3'b000,4'b1100,32'h6C,32'hA5A5_A5A5,32'h0,32'h0,5'd0,5'd0));
        vecs.push_back(mk(0,0,0,5'd0,32'h0,32'hFD09_8123,32'h70,
            2'b00,3'b000,4'b0000,32'h70,32'h1234_5678,32'h0000_00AA,
            32'hFFFF_8123,5'd9,5'd16));
        vecs.push_back(mk(1,1,1,5'd7,32'h0000_0077,32'h8D09_FFFC,32'h74,
            2'b00,3'b000,4'b0000,32'h0,32'h0,32'h0,32'h0,5'd0,5'd0));
        vecs.push_back(mk(0,0,0,5'd0,32'h0,32'h8CE9_FFFC,32'h100,
            2'b11,3'b010,4'b0001,32'h100,32'h0,32'h0,
            32'hFFFF_FFFC,5'd9,5'd31));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            compare(vecs[i], i);
        end

        // Randomized phase: start from a known reset
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        v = mk(1,0,0,5'd0,32'h0,32'h0,32'h0,
               2'b0,3'b0,4'b0,32'h0,32'h0,32'h0,32'h0,5'd0,5'd0);
        drive(v);
        @(posedge clk);
        #1;

        for (int n = 0; n < 400; n++) begin
            logic [5:0] op;
            int sel;
            sel = $urandom_range(0, 4);
            case (sel)
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                default: op = 6'($urandom);
            endcase
            v.rst   = ($urandom_range(0, 49) == 0);
            v.pcsrc = ($urandom_range(0, 4) == 0);
            v.we    = $urandom_range(0, 1) == 1;
            v.wreg  = 5'($urandom_range(0, 7));
            v.wdata = $urandom;
            v.npc   = $urandom;
            v.instr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       16'($urandom)};

            if (v.rst) begin
                v.wb = 0; v.m = 0; v.ex = 0; v.e_npc = 0;
                v.rd1 = 0; v.rd2 = 0; v.sext = 0; v.rt = 0; v.rd = 0;
            end else begin
                c = v.pcsrc ? 9'd0 : ctrl_of(op);
                v.wb    = c[8:7];
                v.m     = c[6:4];
                v.ex    = c[3:0];
                v.e_npc = v.npc;
                v.rd1   = model_read(v.instr[25:21], v);
                v.rd2   = model_read(v.instr[20:16], v);
                v.sext  = 32'(signed'(v.instr[15:0]));
                v.rt    = v.instr[20:16];
                v.rd    = v.instr[15:11];
            end

            drive(v);
            @(posedge clk);
            #1;
            compare(v, 1000 + n);

            if (v.rst) begin
                for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
            end else if (v.we && v.wreg != 0) begin
                mregs[v.wreg] = v.wdata;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
